inst_loader: RTL and testbench

Boot-time program loader that sits between the serial byte receiver and instruction memory. It consumes a byte stream over a valid/ready handshake and packs each four bytes into one INST_WIDTH (32-bit) instruction word, most significant byte first. It writes each word to consecutive instruction-memory addresses from 0 and stops at an end-marker word. It is the producer of the instruction bits that the decode stage later splits into op/r0/r1/r2/constant fields.

---
 rtl/inst_loader.sv | 158 +++++++++++++++
 tb/tb_inst_loader.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_loader.sv
// inst_loader: packs a boot byte stream (most significant byte first) into 32-bit
// instruction words and writes them from address 0 until END_MARKER arrives.
// Define INST_LOADER_CHECKSUM_EN to require a trailing modulo-256 checksum byte.
module inst_loader #(
    parameter int          ADDR_WIDTH = 14,
    parameter logic [31:0] END_MARKER = 32'hFFFF_FFFF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic                  overflow,
    output logic                  cksum_err
);

`ifdef INST_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, RECV, WRITE, CHECK, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE} state_t;
`endif

    // Full memory: the counter reaches 2**ADDR_WIDTH while the address has wrapped to 0.
    localparam logic [ADDR_WIDTH:0] MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t      state;
    state_t      state_next;
    logic [1:0]  byte_idx;
    logic [31:0] word;
    logic [31:0] word_next;
    logic        accept;
    logic        last_byte;
    logic        restart;

`ifdef INST_LOADER_CHECKSUM_EN
    logic [7:0]  sum;
    logic        cksum_q;
    assign cksum_err = cksum_q;
`else
    assign cksum_err = 1'b0;
`endif

    // Shifting left by a byte places the first byte of a word in [31:24].
    assign word_next  = {word[23:0], in_data};
    assign last_byte  = (state == RECV) && accept && (byte_idx == 2'd3);
    assign restart    = start && ((state == IDLE) || (state == DONE));
    assign imem_wdata = word;

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        imem_we    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = RECV;
            end
            RECV: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            WRITE: begin
                imem_we    = 1'b1;
                busy       = 1'b1;
                state_next = RECV;
            end
`ifdef INST_LOADER_CHECKSUM_EN
            CHECK: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
`endif
            DONE: begin
                done = 1'b1;
                if (start) state_next = RECV;
            end
            default: state_next = IDLE;
        endcase

        accept = in_valid && in_ready;

        if ((state == RECV) && accept && (byte_idx == 2'd3)) begin
            if (word_next == END_MARKER) begin
`ifdef INST_LOADER_CHECKSUM_EN
                state_next = CHECK;
`else
                state_next = DONE;
`endif
            end else if (word_count == MAX_WORDS) begin
                state_next = DONE;
            end else begin
                state_next = WRITE;
            end
        end
`ifdef INST_LOADER_CHECKSUM_EN
        if ((state == CHECK) && accept) state_next = DONE;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            byte_idx   <= '0;
            word       <= '0;
            imem_addr  <= '0;
            word_count <= '0;
            overflow   <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
            sum        <= '0;
            cksum_q    <= 1'b0;
`endif
        end else begin
            state <= state_next;

            if (restart) begin
                byte_idx   <= '0;
                imem_addr  <= '0;
                word_count <= '0;
                overflow   <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
                sum        <= '0;
                cksum_q    <= 1'b0;
`endif
            end

            if ((state == RECV) && accept) begin
                byte_idx <= byte_idx + 2'd1;
                word     <= word_next;
`ifdef INST_LOADER_CHECKSUM_EN
                sum      <= sum + in_data;
`endif
            end

            if (last_byte && (word_next != END_MARKER) && (word_count == MAX_WORDS))
                overflow <= 1'b1;

            if (state == WRITE) begin
                imem_addr  <= imem_addr + ADDR_WIDTH'(1);
                word_count <= word_count + (ADDR_WIDTH + 1)'(1);
            end

`ifdef INST_LOADER_CHECKSUM_EN
            // The checksum byte itself is compared, never accumulated.
            if ((state == CHECK) && accept)
                cksum_q <= (in_data != sum);
`endif
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: directed and randomized byte streams
// compared against a word-level model of the loader.
`timescale 1ns/1ps
module tb_inst_loader;
    localparam int          AW     = 2;
    localparam int          DEPTH  = 1 << AW;
    localparam logic [31:0] MARKER = 32'hFFFF_FFFF;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          busy;
    logic          done;
    logic [AW:0]   word_count;
    logic          overflow;
    logic          cksum_err;

    int cyc = 0;
    int n_total = 0;
    int n_pass = 0;

    int          exp_addr[$];
    logic [31:0] exp_data[$];
    int          seen_addr[$];
    logic [31:0] seen_data[$];

    inst_loader #(.ADDR_WIDTH(AW), .END_MARKER(MARKER)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .busy(busy), .done(done), .word_count(word_count), .overflow(overflow),
        .cksum_err(cksum_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    // Every write must match the model's next expected (address, word) pair.
    always @(negedge clk) begin
        if (rst_n) begin
            check("we_and_ready", {63'b0, imem_we & in_ready}, 64'd0);
            check("done_and_busy", {63'b0, done & busy}, 64'd0);
            if (imem_we) begin
                seen_addr.push_back(int'(imem_addr));
                seen_data.push_back(imem_wdata);
                if (exp_addr.size() == 0) begin
                    check("unexpected_write", {63'b0, imem_we}, 64'd0);
                end else begin
                    check("write_addr", imem_addr, exp_addr.pop_front());
                    check("write_data", imem_wdata, exp_data.pop_front());
                end
            end
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_imem_we"}, imem_we, 0);
        check({tag, "_imem_addr"}, imem_addr, 0);
        check({tag, "_imem_wdata"}, imem_wdata, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_word_count"}, word_count, 0);
        check({tag, "_overflow"}, overflow, 0);
        check({tag, "_cksum_err"}, cksum_err, 0);
    endtask

    // Called at a negedge; returns at the negedge of the cycle after the start edge.
    task automatic do_start(output int n0);
        seen_addr.delete();
        seen_data.delete();
        n0 = cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_ready", in_ready, 1);
        check("start_busy", busy, 1);
        check("start_done_clr", done, 0);
        check("start_count_clr", word_count, 0);
        check("start_ovf_clr", overflow, 0);
    endtask

    task automatic send_byte(input logic [7:0] b, input int maxgap);
        int g;
        g = (maxgap > 0 && $urandom_range(1, 0) == 1) ? int'($urandom_range(maxgap, 1)) : 0;
        repeat (g) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        for (int t = 0; t < 20 && !in_ready; t++) @(negedge clk);
        if (!in_ready) begin
            check("byte_accept_timeout", in_ready, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // chk < 0 sends the correct checksum byte; pulse_at >= 0 pulses start before that byte.
    task automatic run_load(input logic [31:0] words[$], input int maxgap, input int chk,
                            input int pulse_at);
        logic [7:0] bytes[$];
        logic [7:0] sum = 8'h00;
        logic [7:0] chk_byte;
        int         cnt = 0;
        int         n0;
        int         lat;
        bit         ovf = 1'b0;
        bit         by_marker = 1'b0;
        bit         exp_cerr = 1'b0;
        foreach (words[i]) begin
            for (int b = 3; b >= 0; b--) begin
                bytes.push_back(words[i][8*b +: 8]);
                sum += words[i][8*b +: 8];
            end
            if (words[i] == MARKER) begin
                by_marker = 1'b1;
                break;
            end
            if (cnt == DEPTH) begin
                ovf = 1'b1;
                break;
            end
            exp_addr.push_back(cnt % DEPTH);
            exp_data.push_back(words[i]);
            cnt++;
        end
        chk_byte = (chk < 0) ? sum : 8'(chk);
        lat = 5 * cnt + 5;
`ifdef INST_LOADER_CHECKSUM_EN
        if (by_marker) begin
            bytes.push_back(chk_byte);
            exp_cerr = (chk_byte != sum);
            lat = lat + 1;
        end
`endif
        do_start(n0);
        foreach (bytes[i]) begin
            if (i == pulse_at) begin
                in_valid = 1'b0;
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            send_byte(bytes[i], maxgap);
        end
        for (int t = 0; t < 40 && !done; t++) @(negedge clk);
        if (maxgap == 0 && pulse_at < 0 && by_marker)
            check("load_latency", cyc - n0, lat);
        check("done", done, 1);
        check("word_count", word_count, cnt);
        check("overflow", overflow, ovf);
        check("cksum_err", cksum_err, exp_cerr);
        check("writes_outstanding", exp_addr.size(), 0);
        exp_addr.delete();
        exp_data.delete();
        in_valid = 1'b1;
        in_data  = 8'hA5;
        repeat (3) begin
            @(negedge clk);
            check("done_held", done, 1);
            check("done_not_ready", in_ready, 0);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] w[$];
        int n0;
        #1;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_zero("idle");

        // Directed two-word program, valid held high.
        w = '{32'h0C22_0005, 32'h8000_0010, MARKER};
        run_load(w, 0, -1, -1);
        check("dir_nwrites", seen_addr.size(), 2);
        if (seen_addr.size() == 2) begin
            check("dir_addr0", seen_addr[0], 0);
            check("dir_data0", seen_data[0], 32'h0C22_0005);
            check("dir_addr1", seen_addr[1], 1);
            check("dir_data1", seen_data[1], 32'h8000_0010);
        end
        check("dir_count_lit", word_count, 2);

        // Same stream with random valid gaps.
        run_load(w, 3, -1, -1);
        check("gap_nwrites", seen_addr.size(), 2);

        // Memory fills before the marker.
        w = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 32'h5555_5555, MARKER};
        run_load(w, 1, -1, -1);
        check("ovf_lit", overflow, 1);
        check("ovf_count_lit", word_count, 4);
        check("ovf_nwrites", seen_addr.size(), 4);
        if (seen_addr.size() == 4) check("ovf_last_addr", seen_addr[3], 3);

        // Start pulsed mid-load is ignored.
        w = '{32'hDEAD_BEEF, 32'h0123_4567, MARKER};
        run_load(w, 0, -1, 5);
        check("pulse_count_lit", word_count, 2);

        // Asynchronous reset after two bytes of a word.
        do_start(n0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        #2 rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        w = '{MARKER};
        run_load(w, 0, -1, -1);
        check("marker_only_count", word_count, 0);
        check("marker_only_nwrites", seen_addr.size(), 0);

`ifdef INST_LOADER_CHECKSUM_EN
        w = '{32'h0000_0001, MARKER};
        run_load(w, 0, 8'hFD, -1);
        check("cksum_good_lit", cksum_err, 0);
        run_load(w, 0, 8'h00, -1);
        check("cksum_bad_lit", cksum_err, 1);
`endif

        // Randomized programs, some long enough to overflow.
        for (int r = 0; r < 25; r++) begin
            int nw;
            int chk;
            int pulse;
            w.delete();
            nw = int'($urandom_range(5, 0));
            for (int i = 0; i < nw; i++) w.push_back($urandom);
            w.push_back(MARKER);
            chk   = ($urandom_range(1, 0) == 1) ? -1 : int'($urandom_range(255, 0));
            pulse = ($urandom_range(3, 0) == 0) ? int'($urandom_range(12, 1)) : -1;
            run_load(w, (r % 3 == 0) ? 0 : 3, chk, pulse);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1);
    end

endmodule
